// File: rtl/alu_seq_if.sv
// Operand/result bundle between an ALU producer (master) and alu_seq (slave).
// Handshake: a beat transfers on a rising edge where valid and ready are both high.
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [2:0]       func;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             out_ready;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;

  modport master (
    output op1, op2, func, in_valid, out_ready,
    input  in_ready, result, out_valid, zero, negative, carry, overflow
  );

  modport slave (
    input  op1, op2, func, in_valid, out_ready,
    output in_ready, result, out_valid, zero, negative, carry, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops, WIDTH-cycle shift-add multiply,
// result and flags held in a one-entry output register with backpressure.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus,
  output logic [1:0] state_dbg
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic               ready_en;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               negative_q;
  logic               carry_q;
  logic               overflow_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  logic               accept;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     ext;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] acc_next;

  // ready_en keeps in_ready low while in reset and until the first edge after release
  assign bus.in_ready  = ready_en & ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign state_dbg     = state;

  assign shamt    = bus.op2[SHW-1:0];
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    ext     = '0;
    case (bus.func)
      3'd0: begin
        ext     = {1'b0, bus.op1} + {1'b0, bus.op2};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) && (alu_res[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      3'd1: begin
        alu_res = bus.op1 - bus.op2;
        alu_c   = (bus.op1 < bus.op2);
        alu_v   = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) && (alu_res[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      3'd2: alu_res = bus.op1 & bus.op2;
      3'd3: alu_res = bus.op1 | bus.op2;
      3'd4: alu_res = bus.op1 ^ bus.op2;
      // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
      3'd5: begin
        ext     = {1'b0, bus.op1} << shamt;
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      3'd6: begin
        ext     = {bus.op1, 1'b0} >> shamt;
        alu_res = ext[WIDTH:1];
        alu_c   = ext[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ready_en   <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (bus.func == 3'd7) begin
              state  <= BUSY;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, bus.op1};
              mplier <= bus.op2;
              cnt    <= '0;
            end else begin
              state      <= DONE;
              result_q   <= alu_res;
              zero_q     <= (alu_res == '0);
              negative_q <= alu_res[WIDTH-1];
              carry_q    <= alu_c;
              overflow_q <= alu_v;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Last multiplier bit: publish straight from acc_next rather than waiting a cycle.
          if (cnt == SHW'(WIDTH - 1)) begin
            state      <= DONE;
            result_q   <= acc_next[WIDTH-1:0];
            zero_q     <= (acc_next[WIDTH-1:0] == '0);
            negative_q <= acc_next[WIDTH-1];
            carry_q    <= |acc_next[2*WIDTH-1:WIDTH];
            overflow_q <= |acc_next[2*WIDTH-1:WIDTH];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal values 4..32.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount field width, derived and not overridden.
REQ-003 clk  input  1  rising-edge clock; sole clock domain.
REQ-004 rst_n  input  1  asynchronous reset, active low.
REQ-005 op1  input  WIDTH  operand A.
REQ-006 op2  input  WIDTH  operand B; for shifts only op2[SHW-1:0] is used.
REQ-007 func  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL.
REQ-008 in_valid  input  1  op1/op2/func valid this cycle.
REQ-009 in_ready  output  1  block can accept an operation this cycle.
REQ-010 result  output  WIDTH  registered result.
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 zero, negative, carry, overflow  output  1 each  registered status flags, valid with out_valid.

Function
REQ-014 Accept = in_valid & in_ready at a rising edge; op1/op2/func are captured only on accept.
REQ-015 States: IDLE, BUSY, DONE.
REQ-016 IDLE: in_ready=1, out_valid=0; accept of func 0-6 -> DONE; accept of MUL -> BUSY; no accept -> stay.
REQ-017 Ops 0-6: result and flags computed from the captured inputs, registered on the accept edge; out_valid=1 on the next cycle (latency 1).
REQ-018 ADD/SUB: result wraps modulo 2^WIDTH; ADD carry = carry-out bit WIDTH; SUB carry = borrow (op1 < op2 unsigned); overflow = two's-complement signed overflow.
REQ-019 AND/OR/XOR: carry=0, overflow=0.
REQ-020 SLL/SRL: logical shift by op2[SHW-1:0] with zero fill; shift 0 returns op1; carry = last bit shifted out (0 for shift 0); overflow=0.
REQ-021 MUL: unsigned iterative shift-add, one multiplier bit per cycle; BUSY for exactly WIDTH cycles, then DONE; out_valid asserts WIDTH+1 cycles after the accept edge.
REQ-022 MUL: result = low WIDTH bits of the 2*WIDTH product; carry = overflow = OR of the high WIDTH bits.
REQ-023 All ops: zero = (result == 0); negative = result[WIDTH-1].
REQ-024 BUSY: in_ready=0, out_valid=0; in_valid is ignored.
REQ-025 DONE: out_valid=1; result and flags held stable until out_ready=1.
REQ-026 DONE with out_ready=1: in_ready=1 that cycle; a simultaneous accept starts the new operation (-> DONE or BUSY) with no idle bubble; otherwise -> IDLE.
REQ-027 DONE with out_ready=0: in_ready=0; state, result and flags unchanged.
REQ-028 result and flags change only on an op-0..6 accept or on MUL completion; they hold their last value in IDLE.
REQ-029 out_ready while out_valid=0 has no effect.

Reset
REQ-030 rst_n low asynchronously forces IDLE: result=0, zero=0, negative=0, carry=0, overflow=0, out_valid=0, MUL accumulator and counter cleared.
REQ-031 in_ready=1 from the first rising clk after rst_n deasserts.
REQ-032 Reset during BUSY or DONE aborts the operation; the aborted result is never presented.

Verification (WIDTH=8)
REQ-033 ADD 8'hFF+8'h01, out_ready=1 -> next cycle: result=8'h00, zero=1, carry=1, overflow=0, out_valid=1 for one cycle.
REQ-034 SUB 8'h80-8'h01 -> result=8'h7F, overflow=1, carry=0, negative=0; SUB 8'h01-8'h02 -> result=8'hFF, carry=1, negative=1.
REQ-035 MUL 8'h10*8'h11 -> in_ready=0 for 8 BUSY cycles; out_valid on cycle 9: result=8'h10, carry=1, overflow=1. MUL 8'h0F*8'h11 -> result=8'hFF, carry=0.
REQ-036 SLL 8'h81 by op2=8'h09 (amount 1) -> result=8'h02, carry=1; SRL 8'h01 by 0 -> result=8'h01, carry=0.
REQ-037 Backpressure: out_ready=0 for 5 cycles after AND 8'hF0&8'h3C -> result=8'h30 held stable, in_ready=0; then out_ready=1 with in_valid=1 (XOR 8'hFF^8'hFF) -> next cycle result=8'h00, zero=1, no bubble.
REQ-038 Reset mid-MUL (rst_n low in BUSY cycle 4) -> all outputs 0 immediately; after release: in_ready=1, out_valid stays 0 until a new accept.
